// File: rtl/msu_axis_bridge.sv
// AXI-stream bridge between the host word-array interface and the MSU s_axis/m_axis ports.
// It buffers one job, streams it to the MSU, collects the result and reports size and watchdog errors.
module msu_axis_bridge #(
    parameter int AXI_LEN         = 32,
    parameter int IN_XFERS        = 8,
    parameter int OUT_XFERS       = 12,
    parameter int XFER_SIZE_WIDTH = 32,
    parameter int TIMEOUT_CYCLES  = 1048576,
    parameter int JOB_CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [AXI_LEN*IN_XFERS-1:0]  msu_in,
    input  logic                         msu_in_valid,
    output logic [AXI_LEN*OUT_XFERS-1:0] msu_out,
    output logic                         valid,
    input  logic                         reduction_we,
    output logic                         reduction_ready,
    output logic                         busy,
    output logic                         size_err,
    output logic                         timeout_err,
    output logic [JOB_CNT_W-1:0]         job_count,
    output logic                         ap_start,
    input  logic                         ap_done,
    input  logic                         start_xfer,
    output logic                         s_axis_tvalid,
    output logic [AXI_LEN-1:0]           s_axis_tdata,
    output logic                         s_axis_tlast,
    input  logic                         s_axis_tready,
    input  logic [XFER_SIZE_WIDTH-1:0]   s_axis_xfer_size_in_bytes,
    input  logic                         m_axis_tvalid,
    input  logic [AXI_LEN-1:0]           m_axis_tdata,
    input  logic                         m_axis_tlast,
    output logic                         m_axis_tready,
    input  logic [XFER_SIZE_WIDTH-1:0]   m_axis_xfer_size_in_bytes
);
    localparam int NW = $clog2(IN_XFERS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [XFER_SIZE_WIDTH-1:0] BPX   = XFER_SIZE_WIDTH'(AXI_LEN / 8);
    localparam logic [XFER_SIZE_WIDTH-1:0] IN_X  = XFER_SIZE_WIDTH'(IN_XFERS);
    localparam logic [XFER_SIZE_WIDTH-1:0] OUT_X = XFER_SIZE_WIDTH'(OUT_XFERS);
    // A stalled cycle with the counter here would make it reach TIMEOUT_CYCLES-1.
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, CAPTURE, SEND, AWAIT, RECV, DONE} state_t;
    state_t state;

    logic [AXI_LEN-1:0]         buffer [IN_XFERS];
    logic [NW-1:0]              n_beats, idx, next_idx, last_idx, cap_n;
    logic [AXI_LEN-1:0]         next_word;
    logic [XFER_SIZE_WIDTH-1:0] m_beats, rx_idx, rx_last;
    logic [XFER_SIZE_WIDTH-1:0] cap_words, cap_rem, res_words, res_rem;
    logic [WW-1:0]              wd_cnt;
    logic                       red_mode, cap_err, s_hs, m_hs, timed, progress;

    assign reduction_ready = reduction_we && (state == IDLE || state == CAPTURE);
    assign busy            = (state != IDLE);

    assign s_hs      = s_axis_tvalid && s_axis_tready;
    assign m_hs      = m_axis_tvalid && m_axis_tready;
    assign next_idx  = idx + NW'(1);
    assign last_idx  = n_beats - NW'(1);
    assign rx_last   = m_beats - XFER_SIZE_WIDTH'(1);
    assign cap_words = s_axis_xfer_size_in_bytes / BPX;
    assign cap_rem   = s_axis_xfer_size_in_bytes % BPX;
    assign res_words = m_axis_xfer_size_in_bytes / BPX;
    assign res_rem   = m_axis_xfer_size_in_bytes % BPX;
    assign cap_n     = (cap_words > IN_X) ? NW'(IN_XFERS) : NW'(cap_words);
    assign cap_err   = (cap_rem != '0) || (cap_words > IN_X) ||
                       (!reduction_we && cap_words != IN_X);
    assign timed     = (state == SEND) || (state == AWAIT) || (state == RECV);

    always_comb begin
        progress = 1'b0;
        case (state)
            SEND:    progress = s_hs;
            AWAIT:   progress = red_mode ? ap_done : start_xfer;
            RECV:    progress = m_hs;
            default: progress = 1'b0;
        endcase
    end

    always_comb begin
        next_word = '0;
        for (int k = 0; k < IN_XFERS; k++)
            if (next_idx == NW'(k)) next_word = buffer[k];
    end

    // The job buffer keeps its contents across reset; only the captured payload matters.
    always_ff @(posedge clk) begin
        if (state == CAPTURE && msu_in_valid)
            for (int k = 0; k < IN_XFERS; k++)
                buffer[k] <= msu_in[k*AXI_LEN +: AXI_LEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ap_start      <= 1'b0;
            valid         <= 1'b0;
            s_axis_tvalid <= 1'b0;
            s_axis_tdata  <= '0;
            s_axis_tlast  <= 1'b0;
            m_axis_tready <= 1'b0;
            size_err      <= 1'b0;
            timeout_err   <= 1'b0;
            job_count     <= '0;
            msu_out       <= '0;
            n_beats       <= '0;
            idx           <= '0;
            m_beats       <= '0;
            rx_idx        <= '0;
            wd_cnt        <= '0;
            red_mode      <= 1'b0;
        end else begin
            ap_start <= 1'b0;
            valid    <= 1'b0;
            if (timed && !progress && wd_cnt == WD_LAST) begin
                timeout_err   <= 1'b1;
                state         <= IDLE;
                s_axis_tvalid <= 1'b0;
                s_axis_tlast  <= 1'b0;
                m_axis_tready <= 1'b0;
                wd_cnt        <= '0;
            end else begin
                wd_cnt <= (timed && !progress) ? wd_cnt + WW'(1) : '0;
                case (state)
                    IDLE: if (start) begin
                        size_err    <= 1'b0;
                        timeout_err <= 1'b0;
                        ap_start    <= 1'b1;
                        state       <= CAPTURE;
                    end
                    CAPTURE: if (msu_in_valid) begin
                        red_mode <= reduction_we;
                        n_beats  <= cap_n;
                        idx      <= '0;
                        if (cap_err) size_err <= 1'b1;
                        if (cap_n == '0) begin
                            state <= AWAIT;
                        end else begin
                            state         <= SEND;
                            s_axis_tvalid <= 1'b1;
                            s_axis_tdata  <= msu_in[AXI_LEN-1:0];
                            s_axis_tlast  <= (cap_n == NW'(1));
                        end
                    end
                    SEND: if (s_hs) begin
                        if (idx == last_idx) begin
                            s_axis_tvalid <= 1'b0;
                            s_axis_tlast  <= 1'b0;
                            state         <= AWAIT;
                        end else begin
                            idx          <= next_idx;
                            s_axis_tdata <= next_word;
                            s_axis_tlast <= (next_idx == last_idx);
                        end
                    end
                    AWAIT: if (red_mode) begin
                        if (ap_done) begin
                            job_count <= job_count + JOB_CNT_W'(1);
                            state     <= IDLE;
                        end
                    end else if (start_xfer) begin
                        m_beats <= res_words;
                        rx_idx  <= '0;
                        if (res_rem != '0 || res_words != OUT_X) size_err <= 1'b1;
                        if (res_words == '0) begin
                            valid     <= 1'b1;
                            job_count <= job_count + JOB_CNT_W'(1);
                            state     <= DONE;
                        end else begin
                            m_axis_tready <= 1'b1;
                            state         <= RECV;
                        end
                    end
                    // Beats beyond OUT_XFERS are counted toward M but dropped.
                    RECV: if (m_hs) begin
                        for (int k = 0; k < OUT_XFERS; k++)
                            if (rx_idx == XFER_SIZE_WIDTH'(k))
                                msu_out[k*AXI_LEN +: AXI_LEN] <= m_axis_tdata;
                        if (m_axis_tlast != (rx_idx == rx_last)) size_err <= 1'b1;
                        if (rx_idx == rx_last) begin
                            m_axis_tready <= 1'b0;
                            valid         <= 1'b1;
                            job_count     <= job_count + JOB_CNT_W'(1);
                            state         <= DONE;
                        end else begin
                            rx_idx <= rx_idx + XFER_SIZE_WIDTH'(1);
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_msu_axis_bridge.sv
// Self-checking bench for msu_axis_bridge: directed job sequence with random payloads,
// checked against a transaction-level model of beats, result words, job count and errors.
module tb_msu_axis_bridge;
    logic           clk;
    logic           reset;
    logic           start;
    logic [255:0]   msu_in;
    logic           msu_in_valid;
    logic [383:0]   msu_out;
    logic           valid;
    logic           reduction_we;
    logic           reduction_ready;
    logic           busy;
    logic           size_err;
    logic           timeout_err;
    logic [15:0]    job_count;
    logic           ap_start;
    logic           ap_done;
    logic           start_xfer;
    logic           s_axis_tvalid;
    logic [31:0]    s_axis_tdata;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [31:0]    s_axis_xfer_size_in_bytes;
    logic           m_axis_tvalid;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic [31:0]    m_axis_xfer_size_in_bytes;

    int          total = 0;
    int          bad = 0;
    int          exp_jobs = 0;
    logic [31:0] exp_out [12];

    msu_axis_bridge #(
        .AXI_LEN(32), .IN_XFERS(8), .OUT_XFERS(12), .XFER_SIZE_WIDTH(32),
        .TIMEOUT_CYCLES(16), .JOB_CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .msu_in(msu_in), .msu_in_valid(msu_in_valid),
        .msu_out(msu_out), .valid(valid), .reduction_we(reduction_we),
        .reduction_ready(reduction_ready), .busy(busy), .size_err(size_err),
        .timeout_err(timeout_err), .job_count(job_count), .ap_start(ap_start),
        .ap_done(ap_done), .start_xfer(start_xfer),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .s_axis_xfer_size_in_bytes(s_axis_xfer_size_in_bytes),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tready(m_axis_tready), .m_axis_xfer_size_in_bytes(m_axis_xfer_size_in_bytes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One host job: start, capture, drain the s stream, then either ap_done (reduction)
    // or feed the m stream; abort_at >= 0 asserts reset before that m beat.
    task automatic applyStimulus(input bit red, input int s_bytes, input int s_mode,
                                 input int m_bytes, input int m_tlast_pos, input int m_mode,
                                 input int abort_at);
        logic [31:0] payload [8];
        logic [31:0] word;
        int n, m, k, cyc, stall;
        bit exp_err, rdy, tv;

        @(negedge clk);
        reduction_we = red;
        start = 1'b1;
        #1 checkOutput("red_ready_idle", reduction_ready, red);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ap_start", ap_start, 1);
        checkOutput("busy_capture", busy, 1);
        checkOutput("size_err_clr", size_err, 0);
        checkOutput("timeout_clr", timeout_err, 0);
        checkOutput("red_ready_capture", reduction_ready, red);

        for (int i = 0; i < 8; i++) payload[i] = $urandom;
        for (int i = 0; i < 8; i++) msu_in[i*32 +: 32] = payload[i];
        s_axis_xfer_size_in_bytes = s_bytes;
        msu_in_valid = 1'b1;
        n = s_bytes / 4;
        exp_err = (s_bytes % 4 != 0) || (!red && n != 8) || (n > 8);
        if (n > 8) n = 8;

        k = 0; cyc = 0; stall = 0;
        while (k < n && cyc < 100) begin
            @(negedge clk);
            msu_in_valid = 1'b0;
            cyc++;
            if (cyc == 1) begin
                checkOutput("s_first_valid", s_axis_tvalid, 1);
                checkOutput("red_ready_send", reduction_ready, 0);
            end
            case (s_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 1);
                default: rdy = ($urandom_range(0, 2) != 0) || stall >= 3;
            endcase
            s_axis_tready = rdy;
            if (s_axis_tvalid) begin
                checkOutput($sformatf("s_data%0d", k), s_axis_tdata, payload[k]);
                checkOutput($sformatf("s_last%0d", k), s_axis_tlast, k == n - 1);
                if (rdy) begin k++; stall = 0; end else stall++;
            end
        end
        checkOutput("s_beats", k, n);
        if (s_mode == 0) checkOutput("s_throughput", cyc, n);
        @(negedge clk);
        msu_in_valid = 1'b0;
        s_axis_tready = 1'b0;
        checkOutput("s_idle_after", s_axis_tvalid, 0);

        if (red) begin
            ap_done = 1'b1;
            @(negedge clk);
            ap_done = 1'b0;
            exp_jobs++;
            checkOutput("red_jobs", job_count, 16'(exp_jobs));
            checkOutput("red_busy", busy, 0);
            checkOutput("red_valid", valid, 0);
            checkOutput("red_size_err", size_err, exp_err);
            return;
        end

        m = m_bytes / 4;
        exp_err = exp_err || (m_bytes % 4 != 0) || (m != 12);
        m_axis_xfer_size_in_bytes = m_bytes;
        start_xfer = 1'b1;
        @(negedge clk);
        start_xfer = 1'b0;
        if (m > 0) checkOutput("m_ready", m_axis_tready, 1);

        k = 0; cyc = 0; stall = 0;
        while (k < m && cyc < 100) begin
            if (k == abort_at) begin
                m_axis_tvalid = 1'b0;
                #1 reset = 1'b1;
                #1;
                checkOutput("rst_busy", busy, 0);
                checkOutput("rst_m_ready", m_axis_tready, 0);
                checkOutput("rst_s_valid", s_axis_tvalid, 0);
                checkOutput("rst_s_data", s_axis_tdata, 0);
                checkOutput("rst_valid", valid, 0);
                checkOutput("rst_ap_start", ap_start, 0);
                checkOutput("rst_job_count", job_count, 0);
                checkOutput("rst_size_err", size_err, 0);
                checkOutput("rst_msu_out", |msu_out, 0);
                @(negedge clk);
                reset = 1'b0;
                exp_jobs = 0;
                for (int i = 0; i < 12; i++) exp_out[i] = '0;
                return;
            end
            tv = (m_mode == 0) ? 1'b1 : (($urandom_range(0, 2) != 0) || stall >= 3);
            word = $urandom;
            m_axis_tvalid = tv;
            m_axis_tdata  = word;
            m_axis_tlast  = (k == m_tlast_pos);
            if (tv && m_axis_tready) begin
                if (k < 12) exp_out[k] = word;
                if ((k == m_tlast_pos) != (k == m - 1)) exp_err = 1'b1;
                k++;
                stall = 0;
            end else begin
                stall++;
            end
            @(negedge clk);
            cyc++;
        end
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        checkOutput("m_beats", k, m);
        if (m_mode == 0) checkOutput("m_throughput", cyc, m);
        exp_jobs++;
        checkOutput("valid_pulse", valid, 1);
        checkOutput("job_count", job_count, 16'(exp_jobs));
        checkOutput("done_size_err", size_err, exp_err);
        checkOutput("done_timeout", timeout_err, 0);
        checkOutput("m_ready_off", m_axis_tready, 0);
        for (int i = 0; i < 12; i++)
            checkOutput($sformatf("msu_out%0d", i), msu_out[i*32 +: 32], exp_out[i]);
        @(negedge clk);
        checkOutput("valid_one_cycle", valid, 0);
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        int cyc, sb, mb, mt;
        reset = 1'b1;
        start = 1'b0; msu_in = '0; msu_in_valid = 1'b0; reduction_we = 1'b0;
        ap_done = 1'b0; start_xfer = 1'b0; s_axis_tready = 1'b0;
        s_axis_xfer_size_in_bytes = '0; m_axis_tvalid = 1'b0; m_axis_tdata = '0;
        m_axis_tlast = 1'b0; m_axis_xfer_size_in_bytes = '0;
        for (int i = 0; i < 12; i++) exp_out[i] = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", valid, 0);
        checkOutput("reset_job_count", job_count, 0);
        checkOutput("reset_errs", {size_err, timeout_err}, 0);
        checkOutput("reset_handshake", {ap_start, s_axis_tvalid, m_axis_tready}, 0);
        checkOutput("reset_msu_out", |msu_out, 0);
        checkOutput("reset_red_ready", reduction_ready, 0);
        reset = 1'b0;

        $display("[TB] normal job, continuous ready");
        applyStimulus(1'b0, 32, 0, 48, 11, 0, -1);
        $display("[TB] backpressure");
        applyStimulus(1'b0, 32, 1, 48, 11, 1, -1);
        $display("[TB] reduction mode");
        applyStimulus(1'b1, 16, 0, 0, 0, 0, -1);
        $display("[TB] oversize result stream");
        applyStimulus(1'b0, 32, 0, 56, 13, 0, -1);
        $display("[TB] short result stream and oversize input");
        applyStimulus(1'b0, 40, 2, 40, 9, 1, -1);
        applyStimulus(1'b0, 30, 0, 48, 11, 0, -1);

        $display("[TB] watchdog");
        @(negedge clk);
        reduction_we = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        msu_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s_axis_xfer_size_in_bytes = 32;
        s_axis_tready = 1'b0;
        msu_in_valid = 1'b1;
        @(negedge clk);
        msu_in_valid = 1'b0;
        cyc = 0;
        while (s_axis_tvalid && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("wd_cycles", cyc, 15);
        checkOutput("wd_timeout_err", timeout_err, 1);
        checkOutput("wd_tvalid", s_axis_tvalid, 0);
        checkOutput("wd_busy", busy, 0);
        checkOutput("wd_m_ready", m_axis_tready, 0);
        checkOutput("wd_job_count", job_count, 16'(exp_jobs));

        $display("[TB] job after watchdog");
        applyStimulus(1'b0, 32, 2, 48, 11, 1, -1);
        $display("[TB] reset mid-RECV");
        applyStimulus(1'b0, 32, 0, 48, 11, 0, 5);
        applyStimulus(1'b0, 32, 2, 48, 11, 1, -1);

        $display("[TB] random jobs");
        for (int r = 0; r < 5; r++) begin
            sb = ($urandom_range(0, 3) == 0) ? 4 * $urandom_range(5, 10) : 32;
            mb = ($urandom_range(0, 2) == 0) ? 4 * $urandom_range(9, 14) : 48;
            mt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, mb / 4 - 1) : mb / 4 - 1;
            applyStimulus(1'b0, sb, 2, mb, mt, 1, -1);
        end
        applyStimulus(1'b1, 4 * $urandom_range(1, 8), 2, 0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
